// File: rtl/sdram_init_pkg.sv
// Shared types and default timing for the SDRAM power-up initialisation sequencer.
package sdram_init_pkg;

  typedef enum logic [3:0] {
    StPwrup,
    StWaitPre,
    StPrecharge,
    StWaitRp,
    StRefresh,
    StWaitRfc,
    StLoadMr,
    StWaitMrd,
    StDone
  } state_e;

  // {cs_n, ras_n, cas_n, we_n}
  typedef logic [3:0] cmd_t;

  localparam cmd_t CmdInhibit     = 4'b1111;
  localparam cmd_t CmdNop         = 4'b0111;
  localparam cmd_t CmdPrecharge   = 4'b0010;
  localparam cmd_t CmdAutoRefresh = 4'b0001;
  localparam cmd_t CmdLoadModeReg = 4'b0000;

  localparam int unsigned DefTPwrup = 10000;
  localparam int unsigned DefTPre   = 3;
  localparam int unsigned DefTRp    = 8;
  localparam int unsigned DefTRfc   = 10;
  localparam int unsigned DefNRef   = 16;
  localparam int unsigned DefTMrd   = 18;

  // Sized by the power-up wait, widened if any other wait would not fit.
  function automatic int unsigned timer_width(int unsigned t_pwrup, int unsigned t_pre,
                                              int unsigned t_rp, int unsigned t_rfc,
                                              int unsigned t_mrd);
    int unsigned m;
    m = t_pwrup;
    if (t_pre > m) m = t_pre;
    if (t_rp > m) m = t_rp;
    if (t_rfc > m) m = t_rfc;
    if (t_mrd > m) m = t_mrd;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/sdram_init_timer.sv
// Reloadable down-counter shared by all init-sequence waits; holds at zero.
module sdram_init_timer #(
  parameter int unsigned Width = 14
) (
  input  logic             clk_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  output logic [Width-1:0] value_o,
  output logic             zero_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    cnt_q <= cnt_d;
  end

  assign value_o = cnt_q;
  assign zero_o  = (cnt_q == '0);

endmodule

// File: rtl/sdram_init_seq.sv
// SDRAM power-up sequencer: NOP wait, PRECHARGE ALL, N_REF AUTO REFRESH, LOAD MODE REG, done.
module sdram_init_seq
  import sdram_init_pkg::*;
#(
  parameter int unsigned T_PWRUP = DefTPwrup,
  parameter int unsigned T_PRE   = DefTPre,
  parameter int unsigned T_RP    = DefTRp,
  parameter int unsigned T_RFC   = DefTRfc,
  parameter int unsigned N_REF   = DefNRef,
  parameter int unsigned T_MRD   = DefTMrd
) (
  input  logic        sys_clk,
  input  logic        reset,
  input  logic [12:0] cfg_mode_reg,
  output logic        sdr_cs_n,
  output logic        sdr_ras_n,
  output logic        sdr_cas_n,
  output logic        sdr_we_n,
  output logic [12:0] sdr_addr,
  output logic [1:0]  sdr_ba,
  output logic        sdr_init_done,
  output logic        init_busy
);

  localparam int unsigned CntW = timer_width(T_PWRUP, T_PRE, T_RP, T_RFC, T_MRD);

  state_e      state_q, state_d;
  logic [7:0]  ref_q, ref_d;
  cmd_t        cmd_q, cmd_d;
  logic [12:0] addr_q, addr_d;
  logic [1:0]  ba_q, ba_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;

  logic            tmr_load;
  logic [CntW-1:0] tmr_load_val;
  logic [CntW-1:0] tmr_value;
  logic            tmr_zero;

  sdram_init_timer #(
    .Width(CntW)
  ) u_timer (
    .clk_i     (sys_clk),
    .load_i    (tmr_load),
    .load_val_i(tmr_load_val),
    .value_o   (tmr_value),
    .zero_o    (tmr_zero)
  );

  // Outputs are decoded from the next state, so the registered command lands in the
  // same cycle the FSM enters that state. Wait loads are T-2 because entry and exit
  // edges each consume a cycle; WAIT_PRE starts on the last power-up NOP, hence T-1.
  always_comb begin
    state_d      = state_q;
    ref_d        = ref_q;
    tmr_load     = 1'b0;
    tmr_load_val = '0;
    cmd_d        = CmdNop;
    addr_d       = '0;
    ba_d         = '0;
    done_d       = 1'b0;
    busy_d       = 1'b1;

    unique case (state_q)
      StPwrup: begin
        if (tmr_zero) begin
          state_d      = StWaitPre;
          tmr_load     = 1'b1;
          tmr_load_val = CntW'(T_PRE - 1);
        end
      end
      StWaitPre: if (tmr_zero) state_d = StPrecharge;
      StPrecharge: begin
        state_d      = StWaitRp;
        tmr_load     = 1'b1;
        tmr_load_val = CntW'(T_RP - 2);
      end
      StWaitRp: if (tmr_zero) state_d = StRefresh;
      StRefresh: begin
        state_d      = StWaitRfc;
        tmr_load     = 1'b1;
        tmr_load_val = CntW'(T_RFC - 2);
      end
      StWaitRfc: begin
        if (tmr_zero) state_d = (ref_q < 8'(N_REF)) ? StRefresh : StLoadMr;
      end
      StLoadMr: begin
        state_d      = StWaitMrd;
        tmr_load     = 1'b1;
        tmr_load_val = CntW'(T_MRD - 2);
      end
      StWaitMrd: if (tmr_zero) state_d = StDone;
      StDone:    state_d = StDone;
      default:   state_d = StPwrup;
    endcase

    if (state_d == StRefresh) ref_d = ref_q + 8'd1;

    case (state_d)
      StPrecharge: begin
        cmd_d      = CmdPrecharge;
        addr_d[10] = 1'b1;
      end
      StRefresh: cmd_d = CmdAutoRefresh;
      StLoadMr: begin
        cmd_d  = CmdLoadModeReg;
        addr_d = cfg_mode_reg;
      end
      StDone: begin
        done_d = 1'b1;
        busy_d = 1'b0;
      end
      default: cmd_d = CmdNop;
    endcase

    if (reset) begin
      tmr_load     = 1'b1;
      tmr_load_val = CntW'(T_PWRUP - 1);
    end
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q <= StPwrup;
      ref_q   <= '0;
      cmd_q   <= CmdInhibit;
      addr_q  <= '0;
      ba_q    <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      ref_q   <= ref_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      ba_q    <= ba_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!reset) assert (tmr_zero == (tmr_value == '0));
  end

  assign {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n} = cmd_q;
  assign sdr_addr      = addr_q;
  assign sdr_ba        = ba_q;
  assign sdr_init_done = done_q;
  assign init_busy     = busy_q;

endmodule

// File: tb/tb_sdram_init_seq.sv
// Self-checking bench: timeline model of the init sequence, checked every cycle on two DUTs.
module tb_sdram_init_seq;

  logic        clk = 1'b0;
  logic        reset_a = 1'b1, reset_b = 1'b1;
  logic [12:0] cfg_a = 13'h1FFF, cfg_b = 13'h0;
  logic        fixed_a = 1'b1;

  logic        cs_a, ras_a, cas_a, we_a, done_a, busy_a;
  logic [12:0] addr_a;
  logic [1:0]  ba_a;
  logic        cs_b, ras_b, cas_b, we_b, done_b, busy_b;
  logic [12:0] addr_b;
  logic [1:0]  ba_b;

  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  sdram_init_seq u_dut_a (
    .sys_clk      (clk),
    .reset        (reset_a),
    .cfg_mode_reg (cfg_a),
    .sdr_cs_n     (cs_a),
    .sdr_ras_n    (ras_a),
    .sdr_cas_n    (cas_a),
    .sdr_we_n     (we_a),
    .sdr_addr     (addr_a),
    .sdr_ba       (ba_a),
    .sdr_init_done(done_a),
    .init_busy    (busy_a)
  );

  sdram_init_seq #(
    .T_PWRUP(4),
    .N_REF  (2)
  ) u_dut_b (
    .sys_clk      (clk),
    .reset        (reset_b),
    .cfg_mode_reg (cfg_b),
    .sdr_cs_n     (cs_b),
    .sdr_ras_n    (ras_b),
    .sdr_cas_n    (cas_b),
    .sdr_we_n     (we_b),
    .sdr_addr     (addr_b),
    .sdr_ba       (ba_b),
    .sdr_init_done(done_b),
    .init_busy    (busy_b)
  );

  // Command timeline as a function of cycle number k (0 = reset seen on last edge).
  function automatic logic [3:0] exp_cmd(int k, int tpw, int tpre, int trp, int trfc,
                                         int nref);
    int p, r0, m;
    p  = tpw + tpre;
    r0 = p + trp;
    m  = r0 + nref * trfc;
    if (k == 0) return 4'b1111;
    if (k == p) return 4'b0010;
    if (k >= r0 && k < m && ((k - r0) % trfc) == 0) return 4'b0001;
    if (k == m) return 4'b0000;
    return 4'b0111;
  endfunction

  function automatic int done_cycle(int tpw, int tpre, int trp, int trfc, int nref,
                                    int tmrd);
    return tpw + tpre + trp + nref * trfc + tmrd;
  endfunction

  task automatic check(string name, int k, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, k, act, exp);
    end
  endtask

  int          k_a = 0, k_b = 0;
  logic [12:0] cfg_a_s, cfg_b_s;
  logic        started = 1'b0;

  always @(posedge clk) begin
    k_a     <= reset_a ? 0 : k_a + 1;
    k_b     <= reset_b ? 0 : k_b + 1;
    cfg_a_s <= cfg_a;
    cfg_b_s <= cfg_b;
    started <= 1'b1;
  end

  // Mode-register stimulus: fixed pattern for the first run, random otherwise.
  always @(posedge clk) begin
    #1;
    if (fixed_a) cfg_a = (k_a + 1 == 10171) ? 13'h0033 : 13'h1FFF;
    else cfg_a = 13'($urandom);
    cfg_b = 13'($urandom);
  end

  // Literal-pin records.
  logic rec1 = 1'b1, rec2 = 1'b0;
  int pre_at = -1, ar_first = -1, ar_last = -1, ar_cnt = 0, lmr_at = -1, done_at = -1;
  int pre2_at = -1, ar_cnt_b = 0, done_at_b = -1;
  logic [12:0] lmr_addr = '0;
  logic        rst_nonfinal_seen = 1'b0;

  always @(negedge clk) begin
    if (started) begin
      logic [3:0] ec, ac;
      logic [12:0] ea;
      int d;
      // DUT A
      ec = exp_cmd(k_a, 10000, 3, 8, 10, 16);
      ac = {cs_a, ras_a, cas_a, we_a};
      ea = (ec == 4'b0010) ? 13'h0400 : (ec == 4'b0000) ? cfg_a_s : 13'h0;
      d  = done_cycle(10000, 3, 8, 10, 16, 18);
      check("a_cmd", k_a, 32'(ac), 32'(ec));
      check("a_addr", k_a, 32'(addr_a), 32'(ea));
      check("a_ba", k_a, 32'(ba_a), 32'(0));
      check("a_done", k_a, 32'(done_a), 32'(k_a >= d));
      check("a_busy", k_a, 32'(busy_a), 32'(k_a < d));
      if (rec1) begin
        if (ac == 4'b0010) pre_at = k_a;
        if (ac == 4'b0001) begin
          ar_cnt++;
          if (ar_first < 0) ar_first = k_a;
          ar_last = k_a;
        end
        if (ac == 4'b0000) begin
          lmr_at   = k_a;
          lmr_addr = addr_a;
        end
        if (done_a && done_at < 0) done_at = k_a;
      end
      if (rec2 && ac == 4'b0010 && pre2_at < 0) pre2_at = k_a;
      // DUT B
      ec = exp_cmd(k_b, 4, 3, 8, 10, 2);
      ac = {cs_b, ras_b, cas_b, we_b};
      ea = (ec == 4'b0010) ? 13'h0400 : (ec == 4'b0000) ? cfg_b_s : 13'h0;
      d  = done_cycle(4, 3, 8, 10, 2, 18);
      check("b_cmd", k_b, 32'(ac), 32'(ec));
      check("b_addr", k_b, 32'(addr_b), 32'(ea));
      check("b_ba", k_b, 32'(ba_b), 32'(0));
      check("b_done", k_b, 32'(done_b), 32'(k_b >= d));
      check("b_busy", k_b, 32'(busy_b), 32'(k_b < d));
      if (rec1) begin
        if (ac == 4'b0001) ar_cnt_b++;
        if (done_b && done_at_b < 0) done_at_b = k_b;
      end
    end
  end

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    // Five reset edges, then the clean default run plus 1000 idle cycles after done.
    tick(5);
    check("rst_cmd_a", 0, 32'({cs_a, ras_a, cas_a, we_a}), 32'hF);
    check("rst_busy_a", 0, 32'(busy_a), 32'(1));
    reset_a = 1'b0;
    reset_b = 1'b0;
    tick(10189 + 1000);
    rec1 = 1'b0;
    check("pin_pre", 0, 32'(pre_at), 32'(10003));
    check("pin_ar_first", 0, 32'(ar_first), 32'(10011));
    check("pin_ar_last", 0, 32'(ar_last), 32'(10161));
    check("pin_ar_cnt", 0, 32'(ar_cnt), 32'(16));
    check("pin_lmr", 0, 32'(lmr_at), 32'(10171));
    check("pin_lmr_addr", 0, 32'(lmr_addr), 32'h0033);
    check("pin_done", 0, 32'(done_at), 32'(10189));
    check("pin_b_ar_cnt", 0, 32'(ar_cnt_b), 32'(2));
    check("pin_b_done", 0, 32'(done_at_b), 32'(53));
    check("idle_cmd", 0, 32'({cs_a, ras_a, cas_a, we_a}), 32'h7);

    // Reset out of DONE held for three edges: INHIBIT throughout.
    fixed_a = 1'b0;
    reset_a = 1'b1;
    tick(1);
    check("rst3_cmd", 0, 32'({cs_a, ras_a, cas_a, we_a}), 32'hF);
    check("rst3_done", 0, 32'(done_a), 32'(0));
    tick(2);
    check("rst3_busy", 0, 32'(busy_a), 32'(1));
    reset_a = 1'b0;

    // One-cycle reset right after the fifth refresh, then time the next PRECHARGE.
    tick(10051);
    check("mid_cmd_ar5", 0, 32'({cs_a, ras_a, cas_a, we_a}), 32'h1);
    reset_a = 1'b1;
    tick(1);
    reset_a = 1'b0;
    rec2 = 1'b1;
    tick(10005);
    check("pin_pre_after_mid_rst", 0, 32'(pre2_at), 32'(10003));

    // Random resets on the small DUT while A finishes its sequence.
    for (int i = 0; i < 4; i++) begin
      reset_b = 1'b1;
      tick(int'($urandom_range(1, 3)));
      reset_b = 1'b0;
      tick(int'($urandom_range(5, 70)));
    end
    tick(250);
    check("final_done_a", 0, 32'(done_a), 32'(1));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
